axis_unpack: RTL and testbench
==============================

// Module: axis_unpack
// PURPOSE
// - AXI-Stream width down-converter: DW_IN-bit words in, DW_OUT-bit beats out, LSB chunk first.
// - Sits directly downstream of the 8->32 packing register stage.
// - Serialises packed words back to byte beats for the byte-wide consumer.
// - Full throughput: a new word is accepted on the same cycle the last beat of the previous word is taken.
// PARAMETERS
// - DW_IN   32  input word width; must be an integer multiple of DW_OUT
// - DW_OUT  8   output beat width
// - RATIO = DW_IN/DW_OUT (localparam, not user-settable)
// PORTS
// - clk        in   1       single clock; all logic on rising edge
// - reset_n    in   1       asynchronous active-low reset
// - s_tdata    in   DW_IN   input word
// - s_tvalid   in   1       input word valid
// - s_tlast    in   1       input word is last of packet
// - s_tready   out  1       unpacker can accept a word this cycle
// - m_tdata    out  DW_OUT  output beat (registered)
// - m_tvalid   out  1       output beat valid (registered)
// - m_tlast    out  1       output beat is last of packet (registered)
// - m_tready   in   1       downstream accepts beat
// - s_tkeep    in   RATIO   per-chunk keep mask, only with AXIS_UNPACK_KEEP_EN
// BEHAVIOUR
// - Reset (async assert, sync release): state=EMPTY; m_tvalid=0, m_tdata=0, m_tlast=0, count=0, shift reg=0.
// - s_tready is forced to 0 while reset_n=0.
// - FSM EMPTY: m_tvalid=0; s_tready=1.
//   - s_tvalid=1: load word into shift reg; m_tdata<=s_tdata[DW_OUT-1:0]; m_tvalid<=1; count<=RATIO-1; state->BUSY.
//   - Latency: 1 cycle from s handshake edge to first beat visible.
// - FSM BUSY: beat held stable while m_tvalid=1 and m_tready=0; data, last and valid all frozen.
//   - m_tready=1, count>0: shift right by DW_OUT; present next chunk; count--.
//   - m_tready=1, count==0: final beat consumed.
//     - If s_tvalid=1: load the new word (same action as EMPTY); state stays BUSY. Zero bubble.
//     - Else: m_tvalid<=0; state->EMPTY.
// - s_tready = (state==EMPTY) | (m_tready & count==0 & state==BUSY).
//   - Combinational path from m_tready to s_tready is intentional and is the only such path.
// - m_tlast = 1 only on the final beat of a word whose s_tlast was 1; 0 on all other beats.
// - Packet boundaries are word-aligned; no partial-word packets without KEEP.
// - s_tdata/s_tlast are ignored when s_tvalid=0 or s_tready=0. X on s_tdata with s_tvalid=0 must not propagate.
// - Reset mid-word: the remaining beats are discarded; no beat is emitted after reset release until a new word is accepted.
// CONFIGURATION
// - AXIS_UNPACK_KEEP_EN defined:
//   - Adds s_tkeep. Chunks with keep=0 are skipped, with no bubble cycle.
//   - Chunk order is the next set keep bit above the current one.
//   - count is replaced by a remaining-keep mask.
//   - m_tlast is driven on the last kept chunk of an s_tlast word.
//   - A word with s_tkeep=0 is accepted and dropped with no output; if it carries s_tlast, that tlast is lost (documented limitation).
// - AXIS_UNPACK_KEEP_EN undefined: no s_tkeep port; all RATIO chunks are always emitted.
// TESTING
// - Single word: s_tdata=32'h44332211, s_tlast=1, m_tready=1 -> m_tdata 11,22,33,44 on 4 consecutive cycles; m_tlast=1 only with 44; s_tready=1 in the cycle 44 is taken.
// - Back-to-back: words 32'h04030201 then 32'h08070605, both s_tvalid=1, m_tready=1 -> 8 contiguous beats 01..08 with no gap; second word accepted in the cycle 04 is taken.
// - Backpressure: m_tready=0 for 3 cycles while beat 22 is shown -> m_tdata stays 22 and m_tvalid stays 1; s_tready=0; resumes with 33.
// - Reset mid-word: assert reset_n=0 after beat 11 -> m_tvalid=0 and m_tdata=0 immediately; after release, no stale 22/33/44 appears.
// - X/idle input: s_tdata=X with s_tvalid=0 for 5 cycles after reset -> m_tvalid stays 0 and m_tdata stays 8'h00.
// - KEEP (macro on): s_tdata=32'hDDCCBBAA, s_tkeep=4'b1010, s_tlast=1 -> beats BB, DD only; m_tlast=1 with DD.

Source files
------------

// File: rtl/axis_unpack_if.sv
// AXI-Stream bundle used on both sides of axis_unpack.
// tkeep exists only when AXIS_UNPACK_KEEP_EN is defined.
interface axis_unpack_if #(
    parameter int DW = 8,
    parameter int KW = 1
);
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tlast;
    logic          tready;
`ifdef AXIS_UNPACK_KEEP_EN
    logic [KW-1:0] tkeep;
`endif

    modport master (
`ifdef AXIS_UNPACK_KEEP_EN
        output tkeep,
`endif
        output tdata, tvalid, tlast,
        input  tready
    );

    modport slave (
`ifdef AXIS_UNPACK_KEEP_EN
        input  tkeep,
`endif
        input  tdata, tvalid, tlast,
        output tready
    );
endinterface

// File: rtl/axis_unpack.sv
// AXI-Stream width down-converter: DW_IN words in, DW_OUT beats out, LSB chunk first.
// Optional AXIS_UNPACK_KEEP_EN adds s.tkeep and skips chunks whose keep bit is clear.
module axis_unpack #(
    parameter int DW_IN  = 32,
    parameter int DW_OUT = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    axis_unpack_if.slave  s,
    axis_unpack_if.master m
);
    localparam int RATIO = DW_IN / DW_OUT;
    localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;

    typedef enum logic {EMPTY, BUSY} state_t;

    state_t              state;
    logic [DW_IN-1:0]    shreg;
    logic [DW_OUT-1:0]   m_tdata_r;
    logic                m_tvalid_r;
    logic                m_tlast_r;
    logic                word_last;
    logic                s_rdy;

    logic                last_beat;
    logic                ld_valid;
    logic                ld_last;
    logic                adv_last;
    logic [DW_OUT-1:0]   ld_tdata;
    logic [DW_OUT-1:0]   adv_tdata;

`ifdef AXIS_UNPACK_KEEP_EN
    // rem holds the kept chunks still to be shown after the current beat
    logic [RATIO-1:0]    rem;
    logic [RATIO-1:0]    ld_rem;
    logic [RATIO-1:0]    adv_rem;
    logic [CW-1:0]       ld_idx;
    logic [CW-1:0]       adv_idx;

    function automatic logic [CW-1:0] lowest(input logic [RATIO-1:0] mask);
        lowest = '0;
        for (int i = RATIO - 1; i >= 0; i--)
            if (mask[i]) lowest = CW'(i);
    endfunction

    always_comb begin
        ld_idx    = lowest(s.tkeep);
        adv_idx   = lowest(rem);
        ld_rem    = s.tkeep & (s.tkeep - RATIO'(1));
        adv_rem   = rem & (rem - RATIO'(1));
        ld_tdata  = s.tdata[ld_idx*DW_OUT +: DW_OUT];
        adv_tdata = shreg[adv_idx*DW_OUT +: DW_OUT];
        ld_valid  = |s.tkeep;
        ld_last   = s.tlast & ~|ld_rem;
        adv_last  = word_last & ~|adv_rem;
        last_beat = ~|rem;
    end

    assign m.tkeep = '1;
`else
    logic [CW-1:0]       count;
    logic [DW_IN-1:0]    shift_nxt;

    always_comb begin
        shift_nxt = shreg >> DW_OUT;
        ld_tdata  = s.tdata[DW_OUT-1:0];
        adv_tdata = shift_nxt[DW_OUT-1:0];
        ld_valid  = 1'b1;
        ld_last   = s.tlast & (RATIO == 1);
        adv_last  = word_last & (count == CW'(1));
        last_beat = (count == '0);
    end
`endif

    // m.tready -> s.tready is the one deliberate combinational path (zero-bubble reload)
    assign s_rdy    = reset_n & ((state == EMPTY) | ((state == BUSY) & m.tready & last_beat));
    assign s.tready = s_rdy;
    assign m.tdata  = m_tdata_r;
    assign m.tvalid = m_tvalid_r;
    assign m.tlast  = m_tlast_r;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= EMPTY;
            shreg      <= '0;
            m_tdata_r  <= '0;
            m_tvalid_r <= 1'b0;
            m_tlast_r  <= 1'b0;
            word_last  <= 1'b0;
`ifdef AXIS_UNPACK_KEEP_EN
            rem        <= '0;
`else
            count      <= '0;
`endif
        end else if (s.tvalid && s_rdy) begin
            shreg      <= s.tdata;
            word_last  <= s.tlast;
            m_tdata_r  <= ld_tdata;
            m_tlast_r  <= ld_last;
            m_tvalid_r <= ld_valid;
            state      <= ld_valid ? BUSY : EMPTY;
`ifdef AXIS_UNPACK_KEEP_EN
            rem        <= ld_rem;
`else
            count      <= CW'(RATIO - 1);
`endif
        end else if (state == BUSY && m.tready) begin
            if (!last_beat) begin
                m_tdata_r <= adv_tdata;
                m_tlast_r <= adv_last;
`ifdef AXIS_UNPACK_KEEP_EN
                rem       <= adv_rem;
`else
                shreg     <= shift_nxt;
                count     <= count - CW'(1);
`endif
            end else begin
                m_tvalid_r <= 1'b0;
                m_tlast_r  <= 1'b0;
                state      <= EMPTY;
            end
        end
    end
endmodule

// File: tb/tb_axis_unpack.sv
// Directed bench for axis_unpack: per-cycle vector table plus reset, idle and keep sequences.
module tb_axis_unpack;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    axis_unpack_if #(.DW(32), .KW(4)) s_if ();
    axis_unpack_if #(.DW(8),  .KW(1)) m_if ();

    axis_unpack #(.DW_IN(32), .DW_OUT(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .s       (s_if),
        .m       (m_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] sd;
        logic        sv;
        logic        sl;
        logic        mr;
        logic        ev;
        logic [7:0]  ed;
        logic        el;
        logic        er;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [31:0] sd, input logic sv, input logic sl, input logic mr,
                       input logic ev, input logic [7:0] ed, input logic el, input logic er);
        vec_t v;
        v.sd = sd; v.sv = sv; v.sl = sl; v.mr = mr;
        v.ev = ev; v.ed = ed; v.el = el; v.er = er;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] sd, input logic sv, input logic sl, input logic mr);
        s_if.tdata  = sd;
        s_if.tvalid = sv;
        s_if.tlast  = sl;
        m_if.tready = mr;
    endtask

    task automatic check_out(input string tag, input logic ev, input logic [7:0] ed,
                             input logic el, input logic er);
        chk({tag, "_mvalid"}, {31'd0, m_if.tvalid}, {31'd0, ev});
        chk({tag, "_sready"}, {31'd0, s_if.tready}, {31'd0, er});
        if (ev) begin
            chk({tag, "_mdata"}, {24'd0, m_if.tdata}, {24'd0, ed});
            chk({tag, "_mlast"}, {31'd0, m_if.tlast}, {31'd0, el});
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive(32'd0, 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
`ifdef AXIS_UNPACK_KEEP_EN
        s_if.tkeep = 4'hF;
`endif
        do_reset();

        // expected columns are the outputs visible in the cycle the inputs are applied
        //   sdata         sv    sl    mr    ev    edata  el    er
        add(32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        add(32'h44332211, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        add(32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0);
        add(32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0);
        add(32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0);
        add(32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 8'h44, 1'b1, 1'b1);
        // back-to-back words, second taken with beat 04
        add(32'h04030201, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        add(32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0);
        add(32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 8'h02, 1'b0, 1'b0);
        add(32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0);
        add(32'h08070605, 1'b1, 1'b1, 1'b1, 1'b1, 8'h04, 1'b0, 1'b1);
        add(32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 8'h05, 1'b0, 1'b0);
        add(32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 8'h06, 1'b0, 1'b0);
        add(32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0);
        add(32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 8'h08, 1'b1, 1'b1);
        add(32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        // backpressure on beat 22, then on the final beat with a word waiting
        add(32'h44332211, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        add(32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0);
        add(32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0);
        add(32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0);
        add(32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0);
        add(32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0);
        add(32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0);
        add(32'hAABBCCDD, 1'b1, 1'b1, 1'b0, 1'b1, 8'h44, 1'b0, 1'b0);
        add(32'hAABBCCDD, 1'b1, 1'b1, 1'b1, 1'b1, 8'h44, 1'b0, 1'b1);
        add(32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 8'hDD, 1'b0, 1'b0);
        add(32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 8'hCC, 1'b0, 1'b0);
        add(32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 8'hBB, 1'b0, 1'b0);
        add(32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 8'hAA, 1'b1, 1'b1);
        add(32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            drive(vq[i].sd, vq[i].sv, vq[i].sl, vq[i].mr);
            #1;
            check_out($sformatf("vec%0d", i), vq[i].ev, vq[i].ed, vq[i].el, vq[i].er);
        end

        // reset while beat 11 is showing: outputs clear at once, no stale beats later
        @(negedge clk);
        drive(32'h44332211, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        drive(32'h0, 1'b0, 1'b0, 1'b1);
        #1;
        check_out("rst_pre", 1'b1, 8'h11, 1'b0, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("rst_mvalid", {31'd0, m_if.tvalid}, 32'd0);
        chk("rst_mdata",  {24'd0, m_if.tdata},  32'd0);
        chk("rst_mlast",  {31'd0, m_if.tlast},  32'd0);
        chk("rst_sready", {31'd0, s_if.tready}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check_out($sformatf("rst_post%0d", i), 1'b0, 8'h00, 1'b0, 1'b1);
        end
        @(negedge clk);
        drive(32'hA4A3A2A1, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        drive(32'h0, 1'b0, 1'b0, 1'b1);
        #1;
        check_out("rst_new", 1'b1, 8'hA1, 1'b0, 1'b0);
        repeat (4) @(negedge clk);

        // idle with unknown data after reset
        do_reset();
        s_if.tdata  = 'x;
        s_if.tvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("xidle%0d_mvalid", i), {31'd0, m_if.tvalid}, 32'd0);
            chk($sformatf("xidle%0d_mdata", i),  {24'd0, m_if.tdata},  32'd0);
        end

`ifdef AXIS_UNPACK_KEEP_EN
        @(negedge clk);
        drive(32'hDDCCBBAA, 1'b1, 1'b1, 1'b1);
        s_if.tkeep = 4'b1010;
        @(negedge clk);
        drive(32'h0, 1'b0, 1'b0, 1'b1);
        #1;
        check_out("keep_bb", 1'b1, 8'hBB, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        check_out("keep_dd", 1'b1, 8'hDD, 1'b1, 1'b1);
        @(negedge clk);
        #1;
        check_out("keep_idle", 1'b0, 8'h00, 1'b0, 1'b1);
        // all-zero keep word is swallowed
        drive(32'h12345678, 1'b1, 1'b1, 1'b1);
        s_if.tkeep = 4'b0000;
        @(negedge clk);
        drive(32'h0, 1'b0, 1'b0, 1'b1);
        #1;
        check_out("keep_drop", 1'b0, 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        drive(32'h12345678, 1'b1, 1'b0, 1'b1);
        s_if.tkeep = 4'b0100;
        @(negedge clk);
        drive(32'h0, 1'b0, 1'b0, 1'b1);
        #1;
        check_out("keep_one", 1'b1, 8'h34, 1'b0, 1'b1);
        s_if.tkeep = 4'hF;
        @(negedge clk);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
